dict_ctrl: RTL and testbench

DICT_CTRL -- requirements
Module: dict_ctrl

---
 rtl/dict_pkg.sv | 8 +
 rtl/dict_ctrl_if.sv | 27 ++
 rtl/rr_arb2.sv | 14 +
 rtl/dict_ctrl.sv | 95 +++++++++
 tb/tb_dict_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dict_pkg.sv
// dict_pkg: controller state encoding, requester IDs and default widths
package dict_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  localparam int REQ_COMP = 0;
  localparam int REQ_DECOMP = 1;
  localparam int DEF_KEY_WIDTH = 4;
  localparam int DEF_VAL_WIDTH = 8;
endpackage

// File: rtl/dict_ctrl_if.sv
// dict_ctrl_if: load stream, dictionary port and requester/response bus of dict_ctrl
interface dict_ctrl_if import dict_pkg::*; #(
  parameter int KEY_WIDTH = DEF_KEY_WIDTH,
  parameter int VAL_WIDTH = DEF_VAL_WIDTH
);
  logic load_start, load_valid, load_ready, load_done, load_err, dict_ready;
  logic [VAL_WIDTH-1:0] load_data;
  logic dict_we, dict_hit;
  logic [VAL_WIDTH-1:0] dict_wval, dict_val_lookup, dict_val_out;
  logic [KEY_WIDTH-1:0] dict_key_lookup, dict_key_out;
  logic [1:0] req_valid, req_is_val, req_ready;
  logic [2*VAL_WIDTH-1:0] req_data;
  logic rsp_valid, rsp_id, rsp_hit;
  logic [VAL_WIDTH-1:0] rsp_data;
  modport master (
    output load_start, load_valid, load_data, dict_val_out, dict_key_out, dict_hit,
           req_valid, req_is_val, req_data,
    input  load_ready, load_done, load_err, dict_ready, dict_we, dict_wval,
           dict_key_lookup, dict_val_lookup, req_ready, rsp_valid, rsp_id, rsp_hit, rsp_data
  );
  modport slave (
    input  load_start, load_valid, load_data, dict_val_out, dict_key_out, dict_hit,
           req_valid, req_is_val, req_data,
    output load_ready, load_done, load_err, dict_ready, dict_we, dict_wval,
           dict_key_lookup, dict_val_lookup, req_ready, rsp_valid, rsp_id, rsp_hit, rsp_data
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; the last winner drops to lowest priority
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;
  always_comb gnt = !en ? 2'b00 : ptr ? (req[1] ? 2'b10 : {1'b0, req[0]}) : (req[0] ? 2'b01 : {req[1], 1'b0});
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
endmodule

// File: rtl/dict_ctrl.sv
// dict_ctrl: dictionary loader plus arbitrated key/value lookup front end.
// Optional DICT_CTRL_STATS_EN adds saturating hit/miss counters for value lookups.
module dict_ctrl import dict_pkg::*; #(
  parameter int KEY_WIDTH = DEF_KEY_WIDTH,
  parameter int VAL_WIDTH = DEF_VAL_WIDTH
) (
  input logic clk,
  input logic reset,
  dict_ctrl_if.slave bus
`ifdef DICT_CTRL_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);
  state_t state, state_n;
  logic [KEY_WIDTH-1:0] cnt, cnt_n;
  logic done_n, err_n, any, sel, is_val;
  logic [1:0] gnt;
  logic [VAL_WIDTH-1:0] opnd;
  rr_arb2 u_arb (.clk(clk), .reset(reset), .en(state == READY), .req(bus.req_valid), .gnt(gnt));
  assign any = |gnt;
  assign sel = gnt[REQ_DECOMP];
  assign opnd = sel ? bus.req_data[2*VAL_WIDTH-1:VAL_WIDTH] : bus.req_data[VAL_WIDTH-1:0];
  assign is_val = bus.req_is_val[sel];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (bus.load_start) begin
        state_n = LOAD;
        cnt_n = '0;
      end
      LOAD: if (bus.load_start) cnt_n = '0;
      else if (bus.load_valid) begin
        cnt_n = cnt + 1'b1;
        state_n = cnt == '1 ? READY : LOAD;
        done_n = cnt == '1;
      end else if (cnt != '0) begin
        // the external writer's index restarts when dict_we drops, so a gap is fatal
        state_n = IDLE;
        err_n = 1'b1;
      end
      READY: if (bus.load_start) begin
        state_n = LOAD;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.load_ready = state == LOAD && !bus.load_start;
    bus.dict_we = bus.load_ready && bus.load_valid;
    bus.dict_wval = bus.dict_we ? bus.load_data : '0;
    bus.dict_ready = state == READY;
    bus.req_ready = gnt;
    bus.dict_key_lookup = any && !is_val ? opnd[KEY_WIDTH-1:0] : '0;
    bus.dict_val_lookup = any && is_val ? opnd : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.load_done <= 1'b0;
      bus.load_err <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_hit <= 1'b0;
      bus.rsp_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.load_done <= done_n;
      bus.load_err <= err_n;
      bus.rsp_valid <= any;
      bus.rsp_id <= any && sel;
      bus.rsp_hit <= any && (!is_val || bus.dict_hit);
      bus.rsp_data <= !any ? '0 : is_val ? VAL_WIDTH'(bus.dict_key_out) : bus.dict_val_out;
    end
`ifdef DICT_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (bus.load_start) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (any && is_val) begin
      if (bus.dict_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (!bus.dict_hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dict_ctrl.sv
// tb_dict_ctrl: randomized scoreboard bench for dict_ctrl with a behavioural dictionary model
module tb_dict_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  int cyc = 0, n_pass = 0, n_total = 0;
  typedef struct {logic id; logic hit; logic [7:0] data; int cyc;} exp_t;
  exp_t q[$];
  logic [7:0] mem[16];
  logic [3:0] widx = 4'd0;
  logic [7:0] ref_dict[16];
  logic [7:0] ld[16];
  logic loaded = 1'b0, prio = 1'b0;
  dict_ctrl_if #(.KEY_WIDTH(4), .VAL_WIDTH(8)) bus ();
`ifdef DICT_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
  dict_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  dict_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // external dictionary: sequential writer whose index restarts whenever dict_we is low
  always @(posedge clk)
    if (bus.dict_we) begin
      mem[widx] <= bus.dict_wval;
      widx <= widx + 4'd1;
    end else widx <= 4'd0;
  always_comb begin
    bus.dict_val_out = mem[bus.dict_key_lookup];
    bus.dict_key_out = 4'd0;
    bus.dict_hit = 1'b0;
    for (int i = 15; i >= 0; i--)
      if (mem[i] == bus.dict_val_lookup) begin
        bus.dict_key_out = 4'(i);
        bus.dict_hit = 1'b1;
      end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [63:0] outs();
    return {26'd0, bus.load_ready, bus.load_done, bus.load_err, bus.dict_ready, bus.dict_we, bus.dict_wval,
            bus.dict_key_lookup, bus.dict_val_lookup, bus.req_ready, bus.rsp_valid, bus.rsp_id,
            bus.rsp_hit, bus.rsp_data};
  endfunction
  function automatic logic [8:0] vsearch(input logic [7:0] v);
    for (int i = 0; i < 16; i++) if (ref_dict[i] == v) return {1'b1, 8'(i)};
    return 9'd0;
  endfunction
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ev;
    if (!reset) begin
      ev = q.size() != 0 && q[0].cyc == cyc;
      chk("rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
        e = q.pop_front();
        if (bus.rsp_valid) begin
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_hit", bus.rsp_hit, e.hit);
          chk("rsp_data", bus.rsp_data, e.data);
        end
      end
    end
  end
  task automatic do_load(input int n);
    @(posedge clk) #1 bus.load_start = 1'b1;
    loaded = 1'b0;
    @(posedge clk) #1 bus.load_start = 1'b0;
    #1 chk("load_ready", bus.load_ready, 1);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data = ld[i];
      #1 chk("dict_we_wval", {bus.dict_we, bus.dict_wval}, {1'b1, ld[i]});
      @(posedge clk) #1;
    end
    bus.load_valid = 1'b0;
    if (n == 16) begin
      chk("load_done", {bus.load_done, bus.load_err, bus.dict_ready}, 3'b101);
      ref_dict = ld;
      loaded = 1'b1;
      @(posedge clk) #1 chk("load_done_pulse", bus.load_done, 0);
    end else begin
      @(posedge clk) #1 chk("load_err", {bus.load_err, bus.load_done, bus.dict_ready, bus.load_ready}, 4'b1000);
      @(posedge clk) #1 chk("load_err_pulse", bus.load_err, 0);
    end
  endtask
  task automatic req(input logic [1:0] v, input logic [1:0] iv, input logic [7:0] d0, input logic [7:0] d1);
    logic [1:0] eg;
    logic n;
    logic [7:0] d;
    logic [8:0] s;
    exp_t e;
    @(posedge clk) #1;
    bus.req_valid = v;
    bus.req_is_val = iv;
    bus.req_data = {d1, d0};
    #1;
    eg = !loaded ? 2'b00 : v == 2'b11 ? (prio ? 2'b10 : 2'b01) : v;
    chk("req_ready", bus.req_ready, eg);
    if (eg == 2'b00) chk("idle_operands", {bus.dict_key_lookup, bus.dict_val_lookup}, 0);
    else begin
      n = eg[1];
      d = n ? d1 : d0;
      s = vsearch(d);
      e.id = n;
      e.hit = iv[n] ? s[8] : 1'b1;
      e.data = iv[n] ? s[7:0] : ref_dict[d[3:0]];
      e.cyc = cyc + 1;
      q.push_back(e);
      prio = !n;
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = 8'd0;
    bus.req_valid = 2'b00;
    bus.req_is_val = 2'b00;
    bus.req_data = 16'd0;
    #3 chk("reset_outputs", outs(), 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 16; i++) ld[i] = 8'h10 + 8'(i);
    do_load(16);
    do_load(6);
    chk("idle_not_ready", bus.dict_ready, 0);
    do_load(16);
    req(2'b10, 2'b00, 8'h00, 8'h03);
    req(2'b01, 2'b01, 8'h1A, 8'h00);
    req(2'b10, 2'b10, 8'h00, 8'h55);
    req(2'b00, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) req(2'b11, 2'b00, 8'(i), 8'(i + 8));
    req(2'b00, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) ld[i] = 8'($urandom);
    do_load(16);
    for (int i = 0; i < 200; i++)
      req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          $urandom_range(0, 1) ? ref_dict[$urandom_range(0, 15)] : 8'($urandom),
          $urandom_range(0, 1) ? ref_dict[$urandom_range(0, 15)] : 8'($urandom));
    req(2'b00, 2'b00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(posedge clk) #1 bus.load_start = 1'b1;
    loaded = 1'b0;
    @(posedge clk) #1 bus.load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data = ld[i];
      @(posedge clk) #1;
    end
    bus.load_data = ld[8];
    #1 reset = 1'b1;
    #1 chk("reset_mid_load", outs(), 0);
    @(negedge clk) reset = 1'b0;
    bus.load_valid = 1'b0;
    prio = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk) #1 chk("no_err_after_reset", bus.load_err, 0);
    for (int i = 0; i < 16; i++) ld[i] = 8'h10 + 8'(i);
    do_load(16);
    for (int i = 0; i < 20; i++)
      req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 8'h10 + 8'($urandom_range(0, 20)));
    req(2'b00, 2'b00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
